// File: rtl/trigger_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_ctrl_if
//  Description : Host command bus and trigger-stage bus for trigger_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trigger_ctrl_if #(
    parameter int NUM_STAGES = 4
);
    logic                  exec_i;
    logic [7:0]            opc_i;
    logic [31:0]           cmd_i;
    logic [31:0]           stg_cmd_o;
    logic [NUM_STAGES-1:0] stg_set_mask_o;
    logic [NUM_STAGES-1:0] stg_set_val_o;
    logic [NUM_STAGES-1:0] stg_set_cfg_o;
    logic                  stg_arm_o;
    logic [NUM_STAGES-1:0] stg_match_i;
    logic [NUM_STAGES-1:0] stg_run_i;
    logic [1:0]            lvl_o;

    modport master (
        output exec_i, opc_i, cmd_i, stg_match_i, stg_run_i,
        input  stg_cmd_o, stg_set_mask_o, stg_set_val_o, stg_set_cfg_o,
        input  stg_arm_o, lvl_o
    );

    modport slave (
        input  exec_i, opc_i, cmd_i, stg_match_i, stg_run_i,
        output stg_cmd_o, stg_set_mask_o, stg_set_val_o, stg_set_cfg_o,
        output stg_arm_o, lvl_o
    );
endinterface
`default_nettype wire

// File: rtl/trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_ctrl
//  Description : SUMP trigger stage sequencer: opcode decode, level, fire.
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_ctrl #(
    parameter int NUM_STAGES = 4
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    trigger_ctrl_if.slave bus,
    output logic          armed_o,
    output logic          trig_o,
    output logic          run_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2
    } state_t;

    localparam logic [7:0] C_OPC_RESET = 8'h00;
    localparam logic [7:0] C_OPC_ARM   = 8'h01;

    state_t                state_q, state_d;
    logic [1:0]            lvl_q, lvl_d;
    logic [31:0]           stg_cmd_q, stg_cmd_d;
    logic [NUM_STAGES-1:0] set_mask_q, set_mask_d;
    logic [NUM_STAGES-1:0] set_val_q, set_val_d;
    logic [NUM_STAGES-1:0] set_cfg_q, set_cfg_d;
    logic                  arm_q, arm_d;
    logic                  run_q, run_d;

    logic [3:0]            stage_oh;
    logic                  is_cfg_opc;
    logic                  exec_arm;
    logic                  exec_reset;

    always_comb begin
        stage_oh   = 4'b0001 << bus.opc_i[3:2];
        is_cfg_opc = bus.exec_i && (bus.opc_i[7:4] == 4'hC);
        exec_arm   = bus.exec_i && (bus.opc_i == C_OPC_ARM);
        exec_reset = bus.exec_i && (bus.opc_i == C_OPC_RESET);
    end

    // Decode path: stages beyond NUM_STAGES fall off the slice, so no pulse.
    always_comb begin
        stg_cmd_d  = stg_cmd_q;
        set_mask_d = '0;
        set_val_d  = '0;
        set_cfg_d  = '0;
        if (bus.exec_i) begin
            stg_cmd_d = bus.cmd_i;
        end
        if (is_cfg_opc) begin
            case (bus.opc_i[1:0])
                2'd0:    set_mask_d = stage_oh[NUM_STAGES-1:0];
                2'd1:    set_val_d  = stage_oh[NUM_STAGES-1:0];
                2'd2:    set_cfg_d  = stage_oh[NUM_STAGES-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        arm_d   = 1'b0;
        run_d   = 1'b0;
        case (state_q)
            ST_ARMED: begin
                // A reset command beats a coinciding run; an arm here is a no-op.
                if (exec_reset) begin
                    state_d = ST_IDLE;
                    lvl_d   = 2'd0;
                end else begin
                    if ((|bus.stg_match_i) && (lvl_q != 2'd3)) begin
                        lvl_d = lvl_q + 2'd1;
                    end
                    if (|bus.stg_run_i) begin
                        state_d = ST_TRIGGERED;
                        run_d   = 1'b1;
                    end
                end
            end
            default: begin
                if (exec_arm) begin
                    state_d = ST_ARMED;
                    lvl_d   = 2'd0;
                    arm_d   = 1'b1;
                end else if (exec_reset) begin
                    state_d = ST_IDLE;
                    lvl_d   = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lvl_q      <= 2'd0;
            stg_cmd_q  <= 32'd0;
            set_mask_q <= '0;
            set_val_q  <= '0;
            set_cfg_q  <= '0;
            arm_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            stg_cmd_q  <= stg_cmd_d;
            set_mask_q <= set_mask_d;
            set_val_q  <= set_val_d;
            set_cfg_q  <= set_cfg_d;
            arm_q      <= arm_d;
            run_q      <= run_d;
        end
    end

    assign bus.stg_cmd_o      = stg_cmd_q;
    assign bus.stg_set_mask_o = set_mask_q;
    assign bus.stg_set_val_o  = set_val_q;
    assign bus.stg_set_cfg_o  = set_cfg_q;
    assign bus.stg_arm_o      = arm_q;
    assign bus.lvl_o          = lvl_q;
    assign armed_o            = (state_q == ST_ARMED);
    assign trig_o             = (state_q == ST_TRIGGERED);
    assign run_o              = run_q;

endmodule
`default_nettype wire

// File: tb/tb_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigger_ctrl
//  Description : Directed scoreboard bench for trigger_ctrl (4- and 2-stage).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_ctrl;

    typedef struct packed {
        logic [31:0] cmd;
        logic [3:0]  mask;
        logic [3:0]  val;
        logic [3:0]  cfg;
        logic        arm;
        logic [1:0]  lvl;
        logic        armed;
        logic        trig;
        logic        run;
    } exp_t;

    typedef struct packed {
        logic [31:0] cmd;
        logic [1:0]  mask;
        logic [1:0]  val;
        logic [1:0]  cfg;
    } exp2_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic armed4, trig4, run4;
    logic armed2, trig2, run2;
    int   total = 0;
    int   bad   = 0;

    exp_t  exp_q[$];
    string name_q[$];

    trigger_ctrl_if #(.NUM_STAGES(4)) bus4();
    trigger_ctrl_if #(.NUM_STAGES(2)) bus2();

    trigger_ctrl #(.NUM_STAGES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .bus(bus4.slave),
        .armed_o(armed4), .trig_o(trig4), .run_o(run4)
    );

    trigger_ctrl #(.NUM_STAGES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2.slave),
        .armed_o(armed2), .trig_o(trig2), .run_o(run2)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus on the falling edge and queue its expected result.
    task automatic cyc(input string nm, input logic r, input logic ex, input logic [7:0] opc,
                       input logic [31:0] cmd, input logic [3:0] match, input logic [3:0] run,
                       input logic [31:0] e_cmd, input logic [3:0] e_mask, input logic [3:0] e_val,
                       input logic [3:0] e_cfg, input logic e_arm, input logic [1:0] e_lvl,
                       input logic e_armed, input logic e_trig, input logic e_run);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus4.exec_i      = ex;
        bus4.opc_i       = opc;
        bus4.cmd_i       = cmd;
        bus4.stg_match_i = match;
        bus4.stg_run_i   = run;
        bus2.exec_i      = ex;
        bus2.opc_i       = opc;
        bus2.cmd_i       = cmd;
        bus2.stg_match_i = match[1:0];
        bus2.stg_run_i   = run[1:0];
        e = '{cmd: e_cmd, mask: e_mask, val: e_val, cfg: e_cfg, arm: e_arm,
              lvl: e_lvl, armed: e_armed, trig: e_trig, run: e_run};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        exp2_t e2;
        exp2_t a2;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{cmd: bus4.stg_cmd_o, mask: bus4.stg_set_mask_o, val: bus4.stg_set_val_o,
                       cfg: bus4.stg_set_cfg_o, arm: bus4.stg_arm_o, lvl: bus4.lvl_o,
                       armed: armed4, trig: trig4, run: run4};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s (4 stages): got cmd=%h mask=%b val=%b cfg=%b arm=%b lvl=%0d armed=%b trig=%b run=%b, want cmd=%h mask=%b val=%b cfg=%b arm=%b lvl=%0d armed=%b trig=%b run=%b",
                             nm, a.cmd, a.mask, a.val, a.cfg, a.arm, a.lvl, a.armed, a.trig, a.run,
                             e.cmd, e.mask, e.val, e.cfg, e.arm, e.lvl, e.armed, e.trig, e.run);
                end
                e2 = '{cmd: e.cmd, mask: e.mask[1:0], val: e.val[1:0], cfg: e.cfg[1:0]};
                a2 = '{cmd: bus2.stg_cmd_o, mask: bus2.stg_set_mask_o, val: bus2.stg_set_val_o,
                       cfg: bus2.stg_set_cfg_o};
                total++;
                if (a2 !== e2) begin
                    bad++;
                    $display("FAIL %s (2 stages): got cmd=%h mask=%b val=%b cfg=%b, want cmd=%h mask=%b val=%b cfg=%b",
                             nm, a2.cmd, a2.mask, a2.val, a2.cfg, e2.cmd, e2.mask, e2.val, e2.cfg);
                end
            end
        end
    end

    initial begin : stimulus
        bus4.exec_i = 1'b0; bus4.opc_i = 8'h00; bus4.cmd_i = 32'd0;
        bus4.stg_match_i = 4'd0; bus4.stg_run_i = 4'd0;
        bus2.exec_i = 1'b0; bus2.opc_i = 8'h00; bus2.cmd_i = 32'd0;
        bus2.stg_match_i = 2'd0; bus2.stg_run_i = 2'd0;

        //   name            rst ex opc    cmd            match    run      e_cmd          mask     val      cfg      arm lvl armed trig run
        cyc("reset0",        1, 0, 8'h00, 32'h0,        4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("reset1",        1, 0, 8'h00, 32'h0,        4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("idle",          0, 0, 8'h00, 32'h0,        4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("mask_s1",       0, 1, 8'hC4, 32'h000000FF, 4'b0000, 4'b0000, 32'h000000FF, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("cfg_s2",        0, 1, 8'hCA, 32'h12345678, 4'b0000, 4'b0000, 32'h12345678, 4'b0000, 4'b0000, 4'b0100, 0, 0, 0, 0, 0);
        cyc("val_s1",        0, 1, 8'hC5, 32'hAAAA5555, 4'b0000, 4'b0000, 32'hAAAA5555, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0, 0);
        cyc("hold_cmd",      0, 0, 8'hC5, 32'hDEADBEEF, 4'b0000, 4'b0000, 32'hAAAA5555, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("mask_s2",       0, 1, 8'hC8, 32'h00000011, 4'b0000, 4'b0000, 32'h00000011, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("unused_c3",     0, 1, 8'hC3, 32'h00000022, 4'b0000, 4'b0000, 32'h00000022, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("unlisted_7e",   0, 1, 8'h7E, 32'h00000033, 4'b0000, 4'b0000, 32'h00000033, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("idle_ignore",   0, 0, 8'h00, 32'h0,        4'b1111, 4'b1111, 32'h00000033, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("arm",           0, 1, 8'h01, 32'h00000044, 4'b0000, 4'b0000, 32'h00000044, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("lvl1",          0, 0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h00000044, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0, 0);
        cyc("lvl2",          0, 0, 8'h00, 32'h0,        4'b0011, 4'b0000, 32'h00000044, 4'b0000, 4'b0000, 4'b0000, 0, 2, 1, 0, 0);
        cyc("lvl3",          0, 0, 8'h00, 32'h0,        4'b0100, 4'b0000, 32'h00000044, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1, 0, 0);
        cyc("lvl_sat",       0, 0, 8'h00, 32'h0,        4'b1000, 4'b0000, 32'h00000044, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1, 0, 0);
        cyc("arm_in_armed",  0, 1, 8'h01, 32'h00000055, 4'b0000, 4'b0000, 32'h00000055, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1, 0, 0);
        cyc("reset_cmd",     0, 1, 8'h00, 32'h00000066, 4'b0000, 4'b0000, 32'h00000066, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("rearm",         0, 1, 8'h01, 32'h00000077, 4'b0000, 4'b0000, 32'h00000077, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("f_lvl1",        0, 0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h00000077, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0, 0);
        cyc("f_lvl2",        0, 0, 8'h00, 32'h0,        4'b0010, 4'b0000, 32'h00000077, 4'b0000, 4'b0000, 4'b0000, 0, 2, 1, 0, 0);
        cyc("fire",          0, 0, 8'h00, 32'h0,        4'b0000, 4'b0100, 32'h00000077, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 1, 1);
        cyc("fire_after",    0, 0, 8'h00, 32'h0,        4'b0000, 4'b0000, 32'h00000077, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 1, 0);
        cyc("trig_match",    0, 0, 8'h00, 32'h0,        4'b1111, 4'b0000, 32'h00000077, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 1, 0);
        cyc("trig_run",      0, 0, 8'h00, 32'h0,        4'b0000, 4'b0001, 32'h00000077, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 1, 0);
        cyc("arm_from_trig", 0, 1, 8'h01, 32'h00000088, 4'b0000, 4'b0000, 32'h00000088, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("prio_a",        0, 1, 8'h01, 32'h00000099, 4'b0000, 4'b0001, 32'h00000099, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
        cyc("rearm2",        0, 1, 8'h01, 32'h000000AA, 4'b0000, 4'b0000, 32'h000000AA, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("match_and_run", 0, 0, 8'h00, 32'h0,        4'b0010, 4'b1000, 32'h000000AA, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 1, 1);
        cyc("rearm3",        0, 1, 8'h01, 32'h000000BB, 4'b0000, 4'b0000, 32'h000000BB, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("b_lvl1",        0, 0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h000000BB, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0, 0);
        cyc("prio_b",        0, 1, 8'h00, 32'h000000CC, 4'b0001, 4'b0100, 32'h000000CC, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("rearm4",        0, 1, 8'h01, 32'h000000DD, 4'b0000, 4'b0000, 32'h000000DD, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("r_lvl1",        0, 0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h000000DD, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0, 0);
        cyc("r_lvl2",        0, 0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h000000DD, 4'b0000, 4'b0000, 4'b0000, 0, 2, 1, 0, 0);
        cyc("r_lvl3",        0, 0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h000000DD, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1, 0, 0);
        cyc("rst_mid",       1, 1, 8'hC0, 32'h000000EE, 4'b0001, 4'b0001, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("rst_hold",      1, 0, 8'h00, 32'h0,        4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("arm_post_rst",  0, 1, 8'h01, 32'h00000001, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("p_lvl1",        0, 0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h00000001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0, 0);
        cyc("p_fire",        0, 0, 8'h00, 32'h0,        4'b0000, 4'b0001, 32'h00000001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 1, 1);
        cyc("arm_trig2",     0, 1, 8'h01, 32'h00000002, 4'b0000, 4'b0000, 32'h00000002, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        cyc("cfg_armed",     0, 1, 8'hC2, 32'h00000003, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1, 0, 0);
        cyc("final_idle",    0, 0, 8'h00, 32'h0,        4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
